// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared dual-clock FIFO definitions: output-stage FSM encoding and Gray/binary helpers.
// The write side uses the same helpers, so keep them width-agnostic (zero-extended 32-bit).
package fifo_rd_ctrl_pkg;

  localparam int unsigned CONV_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } rd_state_e;

  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down; upper unused bits must be zero.
  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
    logic [CONV_W-1:0] bin;
    bin = gray;
    for (int unsigned i = 1; i < CONV_W; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded FIFO pointer crossing clock domains.
// Only one bit changes per source update, so per-bit sampling stays coherent.
module fifo_ptr_sync #(
  parameter int unsigned W      = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: write-pointer sync, read pointer,
// FWFT output register with valid/ready, and empty / almost-empty / level flags.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned AW          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 1
) (
  input  logic          I_RD_CLK,
  input  logic          I_RD_RST_N,
  input  logic [AW:0]   I_RD_WR_PTR,
  input  logic [DW-1:0] I_RD_DATA,
  output logic [AW-1:0] O_RD_ADDR,
  output logic [AW:0]   O_RD_PTR,
  output logic [DW-1:0] O_RD_DATA,
  output logic          O_RD_VALID,
  input  logic          I_RD_READY,
  output logic          O_RD_EMPTY,
  output logic          O_RD_AEMPTY,
  output logic [AW:0]   O_RD_LEVEL
);

  localparam int unsigned PW = AW + 1;

  rd_state_e     state_q, state_d;
  logic [PW-1:0] wq;
  logic [PW-1:0] wb;
  logic [PW-1:0] r_rd_bin;
  logic [PW-1:0] r_rd_gray;
  logic [PW-1:0] rd_bin_nxt;
  logic [PW-1:0] level;
  logic [DW-1:0] r_data;
  logic          mem_empty;
  logic          load;

  fifo_ptr_sync #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_wr_ptr_sync (
    .clk   (I_RD_CLK),
    .rst_n (I_RD_RST_N),
    .d     (I_RD_WR_PTR),
    .q     (wq)
  );

  // Flags and level derive only from registered pointers.
  assign mem_empty  = (r_rd_gray == wq);
  assign wb         = PW'(gray2bin(CONV_W'(wq)));
  assign level      = wb - r_rd_bin;
  assign rd_bin_nxt = r_rd_bin + PW'(1);
  assign load       = !mem_empty && ((state_q == ST_IDLE) || I_RD_READY);

  // Read pointer (binary + Gray) and FWFT data register.
  always_ff @(posedge I_RD_CLK or negedge I_RD_RST_N) begin
    if (!I_RD_RST_N) begin
      r_rd_bin  <= '0;
      r_rd_gray <= '0;
      r_data    <= '0;
    end else if (load) begin
      r_rd_bin  <= rd_bin_nxt;
      r_rd_gray <= PW'(bin2gray(CONV_W'(rd_bin_nxt)));
      r_data    <= I_RD_DATA;
    end
  end

  always_ff @(posedge I_RD_CLK or negedge I_RD_RST_N) begin
    if (!I_RD_RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output-register occupancy: a load refills, an accept with nothing to load drains.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (I_RD_READY && !load) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign O_RD_ADDR   = r_rd_bin[AW-1:0];
  assign O_RD_PTR    = r_rd_gray;
  assign O_RD_DATA   = r_data;
  assign O_RD_VALID  = (state_q == ST_FULL);
  assign O_RD_EMPTY  = mem_empty;
  assign O_RD_LEVEL  = level;
  assign O_RD_AEMPTY = (level <= PW'(AE_THRESH));

endmodule
